nn_node_feeder: RTL

Transmitter-side companion to `nn_node`: accepts a serial stream of 16-bit words (features, then weights) over a valid/ready handshake and assembles them into the parallel x/w buses `nn_node` consumes. It raises `in_ready` once a frame is complete, holds it until both node outputs report ready, then captures `out0`/`out1` into a result register offered downstream over a second valid/ready handshake. It sits between the host/memory loader and `nn_node`, replacing hand-driven stimulus.

---
 rtl/nn_node_feeder_if.sv | 38 +++
 rtl/nn_node_feeder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/nn_node_feeder_if.sv
// Signal bundle between the stream loader, nn_node_feeder, nn_node and the result consumer.
// The slave modport is the feeder's view; master is the surrounding system's view.
interface nn_node_feeder_if;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_wload;
   logic [15:0] x0, x1, x2, x3;
   logic [15:0] w04, w14, w24, w34;
   logic [15:0] w05, w15, w25, w35;
   logic [15:0] w06, w16, w26, w36;
   logic [15:0] w07, w17, w27, w37;
   logic [15:0] w48, w58, w68, w78;
   logic [15:0] w49, w59, w69, w79;
   logic        in_ready;
   logic [15:0] out0, out1;
   logic        out10_ready, out11_ready;
   logic [15:0] res0, res1;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  frame_cnt;

   modport slave (
      input  s_data, s_valid, s_wload, out0, out1, out10_ready, out11_ready, res_ready,
      output s_ready, in_ready, res0, res1, res_valid, frame_cnt,
      output x0, x1, x2, x3,
      output w04, w14, w24, w34, w05, w15, w25, w35, w06, w16, w26, w36,
      output w07, w17, w27, w37, w48, w58, w68, w78, w49, w59, w69, w79
   );

   modport master (
      output s_data, s_valid, s_wload, out0, out1, out10_ready, out11_ready, res_ready,
      input  s_ready, in_ready, res0, res1, res_valid, frame_cnt,
      input  x0, x1, x2, x3,
      input  w04, w14, w24, w34, w05, w15, w25, w35, w06, w16, w26, w36,
      input  w07, w17, w27, w37, w48, w58, w68, w78, w49, w59, w69, w79
   );
endinterface

// File: rtl/nn_node_feeder.sv
// Assembles a serial 16-bit word stream into nn_node's x/w buses and returns its results.
// Define FEEDER_WEIGHT_HOLD_EN to allow 4-word frames that reuse the previous weights.
module nn_node_feeder (
   input  logic                   clk,
   input  logic                   rst,
   nn_node_feeder_if.slave        feed_if,
   output logic [1:0]             state_o
);
   // Valid/ready: a word moves on s_valid && s_ready, a result on res_valid && res_ready;
   // senders hold data stable while valid is high and unaccepted, and valid never waits on ready.
   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;
   localparam logic [4:0] LAST_FULL  = 5'd27;

   logic [1:0]  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [15:0] word_q [0:27];
   logic [15:0] word_d [0:27];
   logic        in_ready_q, in_ready_d;
   logic        got0_q, got0_d;
   logic        got1_q, got1_d;
   logic [15:0] res0_q, res0_d;
   logic [15:0] res1_q, res1_d;
   logic        res_valid_q, res_valid_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        s_ready;
   logic        accept;
   logic [4:0]  last_idx;

   assign s_ready = (state_q == ST_LOAD) && !rst;
   assign accept  = feed_if.s_valid && s_ready;

`ifdef FEEDER_WEIGHT_HOLD_EN
   localparam logic [4:0] LAST_SHORT = 5'd3;
   logic have_w_q, have_w_d;
   logic short_q, short_d;
   logic short_now;

   // Frame length is decided by s_wload on word 0; weights must have been loaded once since reset.
   assign short_now = (idx_q == 5'd0) ? (have_w_q && !feed_if.s_wload) : short_q;
   assign last_idx  = short_now ? LAST_SHORT : LAST_FULL;
   assign short_d   = (accept && idx_q == 5'd0) ? short_now : short_q;
   assign have_w_d  = have_w_q || (accept && idx_q == LAST_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         have_w_q <= 1'b0;
         short_q  <= 1'b0;
      end else begin
         have_w_q <= have_w_d;
         short_q  <= short_d;
      end
   end
`else
   logic unused_wload;
   assign unused_wload = feed_if.s_wload;
   assign last_idx     = LAST_FULL;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      word_d      = word_q;
      in_ready_d  = in_ready_q;
      got0_d      = got0_q;
      got1_d      = got1_q;
      res0_d      = res0_q;
      res1_d      = res1_q;
      res_valid_d = res_valid_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               word_d[idx_q] = feed_if.s_data;
               if (idx_q == last_idx) begin
                  idx_d      = 5'd0;
                  state_d    = ST_RUN;
                  in_ready_d = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         ST_RUN: begin
            // Only the first strobe of each output is captured.
            if (feed_if.out10_ready && !got0_q) begin
               got0_d = 1'b1;
               res0_d = feed_if.out0;
            end
            if (feed_if.out11_ready && !got1_q) begin
               got1_d = 1'b1;
               res1_d = feed_if.out1;
            end
            if (got0_d && got1_d) begin
               state_d     = ST_RESULT;
               in_ready_d  = 1'b0;
               res_valid_d = 1'b1;
            end
         end
         ST_RESULT: begin
            if (feed_if.res_ready) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               got0_d      = 1'b0;
               got1_d      = 1'b0;
               res_valid_d = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_LOAD;
         idx_q       <= 5'd0;
         in_ready_q  <= 1'b0;
         got0_q      <= 1'b0;
         got1_q      <= 1'b0;
         res0_q      <= 16'd0;
         res1_q      <= 16'd0;
         res_valid_q <= 1'b0;
         frame_cnt_q <= 8'd0;
         for (int i = 0; i < 28; i++) word_q[i] <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         got0_q      <= got0_d;
         got1_q      <= got1_d;
         res0_q      <= res0_d;
         res1_q      <= res1_d;
         res_valid_q <= res_valid_d;
         frame_cnt_q <= frame_cnt_d;
         for (int i = 0; i < 28; i++) word_q[i] <= word_d[i];
      end
   end

   assign state_o           = state_q;
   assign feed_if.s_ready   = s_ready;
   assign feed_if.in_ready  = in_ready_q;
   assign feed_if.res0      = res0_q;
   assign feed_if.res1      = res1_q;
   assign feed_if.res_valid = res_valid_q;
   assign feed_if.frame_cnt = frame_cnt_q;

   assign feed_if.x0  = word_q[0];
   assign feed_if.x1  = word_q[1];
   assign feed_if.x2  = word_q[2];
   assign feed_if.x3  = word_q[3];
   assign feed_if.w04 = word_q[4];
   assign feed_if.w14 = word_q[5];
   assign feed_if.w24 = word_q[6];
   assign feed_if.w34 = word_q[7];
   assign feed_if.w05 = word_q[8];
   assign feed_if.w15 = word_q[9];
   assign feed_if.w25 = word_q[10];
   assign feed_if.w35 = word_q[11];
   assign feed_if.w06 = word_q[12];
   assign feed_if.w16 = word_q[13];
   assign feed_if.w26 = word_q[14];
   assign feed_if.w36 = word_q[15];
   assign feed_if.w07 = word_q[16];
   assign feed_if.w17 = word_q[17];
   assign feed_if.w27 = word_q[18];
   assign feed_if.w37 = word_q[19];
   assign feed_if.w48 = word_q[20];
   assign feed_if.w58 = word_q[21];
   assign feed_if.w68 = word_q[22];
   assign feed_if.w78 = word_q[23];
   assign feed_if.w49 = word_q[24];
   assign feed_if.w59 = word_q[25];
   assign feed_if.w69 = word_q[26];
   assign feed_if.w79 = word_q[27];
endmodule
